pingpong_mux_feeder: RTL and testbench
======================================

Name: pingpong_mux_feeder

Overview:
- Two-bank ping-pong buffer that sits directly upstream of the 2:1 word multiplexer (MUX2).
- Drives the mux's data inputs and select: o_D0/o_D1 connect to i_D0/i_D1, o_s connects to i_s, so the mux output always presents the oldest unread word.
- Accepts words from a producer through a valid/ready handshake.
- Releases them in order through a valid/ready handshake on the consumer side.

Parameters:
- n, 4, data word width in bits; must match MUX2 parameter n.

Ports:
- i_clk  input  1  single system clock; all state updates on posedge.
- i_rst  input  1  asynchronous, active-high reset.
- i_data  input  n  write data word.
- i_valid  input  1  producer has a word on i_data.
- o_ready  output  1  buffer can accept a word this cycle.
- o_D0  output  n  bank 0 contents, to MUX2 i_D0.
- o_D1  output  n  bank 1 contents, to MUX2 i_D1.
- o_s  output  1  bank holding the oldest unread word, to MUX2 i_s.
- o_valid  output  1  the bank selected by o_s holds an unread word.
- i_ready  input  1  consumer takes the selected word this cycle.
- o_count  output  2  number of full banks, 0..2.

Behaviour:
- One clock (i_clk); reset is asynchronous and active-high (i_rst).
- State: bank0[n-1:0], bank1[n-1:0], full[1:0], write pointer wp (1 bit), read pointer rp (1 bit).
- Reset, applied at any time including mid-transfer:
  - clears bank0, bank1, full, wp and rp to 0 immediately, without waiting for a clock edge;
  - resulting outputs: o_D0=0, o_D1=0, o_s=0, o_valid=0, o_ready=1, o_count=0;
  - the first posedge after i_rst deasserts may already accept a write.
- Combinational outputs:
  - o_ready = ~full[wp]
  - o_valid = full[rp]
  - o_s = rp
  - o_count = full[0] + full[1]
  - o_D0 = bank0, o_D1 = bank1 (registered values, no bypass).
- Write (wr = i_valid & o_ready), at posedge:
  - bank[wp] <= i_data
  - full[wp] <= 1
  - wp <= ~wp
- Read (rd = o_valid & i_ready), at posedge:
  - full[rp] <= 0
  - rp <= ~rp
  - bank contents are not cleared on read.
- Latency:
  - a word written at posedge k is visible on o_D(wp) and o_valid after posedge k, i.e. in cycle k+1;
  - MUX2 output equals that word in the same cycle when it is the oldest unread word.
- Handshake rules:
  - i_data is sampled only when wr; i_valid without o_ready has no effect;
  - i_ready without o_valid has no effect;
  - producer holds i_data until accepted; consumer may hold i_ready high continuously.
- Simultaneous write and read in one cycle:
  - legal; wp != rp in that case, so the banks always differ;
  - both updates apply and o_count is unchanged.
- wp == rp implies both banks empty or both full, so a same-bank conflict is impossible:
  - empty (count 0): read blocked, o_valid=0;
  - full (count 2): write blocked, o_ready=0.
- Wrap-around: wp and rp are 1-bit and toggle freely; ordering is strictly FIFO with depth 2.
- Throughput: with both sides always ready, one word per cycle, ping-ponging banks; o_s toggles every cycle after the first write.
- Data width: no arithmetic; words are passed bit-exact, n bits.

Test Plan:
- Reset check: assert i_rst mid-cycle with count=1 -> immediately o_valid=0, o_ready=1, o_count=0, o_D0=o_D1=0, o_s=0.
- Single word: write 4'hA with i_ready=0 ->
  - next cycle o_D0=4'hA, o_s=0, o_valid=1, o_count=1;
  - assert i_ready for 1 cycle -> o_valid=0, o_s=1.
- Fill and block: write 4'h3 then 4'h5, i_ready=0 ->
  - o_count=2, o_ready=0, o_D0=3, o_D1=5;
  - a third i_valid with 4'h7 is ignored, and 4'h7 appears on neither bank.
- Ordering and wrap: stream 4'h0..4'hF with i_ready=1 always ->
  - consumer receives 0..F in order, one per cycle;
  - MUX2 output equals the expected value each cycle;
  - 0 errors.
- Simultaneous read/write at count=1 (bank0=4'h2): write 4'h9 while reading ->
  - next cycle o_count=1, o_s=1, o_D1=9, o_valid=1.
- Reset mid-stream: stream with i_ready toggling, pulse i_rst at count=2 ->
  - all state is zero;
  - the next write of 4'hC lands in bank0 with o_s=0.

Source files
------------

// File: rtl/pingpong_mux_feeder.sv
// Two-bank ping-pong buffer feeding a 2:1 word mux.
// Banks fill alternately; o_s always selects the oldest unread word.
module pingpong_mux_feeder #(
    parameter int n = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [n-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [n-1:0] o_D0,
    output logic [n-1:0] o_D1,
    output logic         o_s,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [1:0]   o_count
);

    logic [n-1:0] bank0_q, bank0_d;
    logic [n-1:0] bank1_q, bank1_d;
    logic [1:0]   full_q, full_d;
    logic         wp_q, wp_d;
    logic         rp_q, rp_d;
    logic         wr, rd;

    // Handshake qualifiers and status outputs straight from state.
    // wp == rp only when both banks share a fill state, so wr and rd
    // can never target the same bank in one cycle.
    assign o_ready = ~full_q[wp_q];
    assign o_valid = full_q[rp_q];
    assign o_s     = rp_q;
    assign o_count = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign o_D0    = bank0_q;
    assign o_D1    = bank1_q;
    assign wr      = i_valid & o_ready;
    assign rd      = o_valid & i_ready;

    // Next-state: write fills bank[wp], read frees bank[rp].
    always_comb begin
        bank0_d = bank0_q;
        bank1_d = bank1_q;
        full_d  = full_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        if (wr) begin
            if (wp_q) begin
                bank1_d = i_data;
            end else begin
                bank0_d = i_data;
            end
            full_d[wp_q] = 1'b1;
            wp_d         = ~wp_q;
        end
        if (rd) begin
            full_d[rp_q] = 1'b0;
            rp_d         = ~rp_q;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bank0_q <= '0;
            bank1_q <= '0;
            full_q  <= '0;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
        end else begin
            bank0_q <= bank0_d;
            bank1_q <= bank1_d;
            full_q  <= full_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
        end
    end

endmodule

// File: tb/tb_pingpong_mux_feeder.sv
// Scoreboard bench for pingpong_mux_feeder: stimulus queues expected
// words, a negedge monitor checks the mux output on every read.
module tb_pingpong_mux_feeder;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] i_data;
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] o_D0;
    logic [N-1:0] o_D1;
    logic         o_s;
    logic         o_valid;
    logic         i_ready;
    logic [1:0]   o_count;

    logic [N-1:0] exp_q[$];
    int           n_cmp;
    int           n_bad;

    pingpong_mux_feeder #(.n(N)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_data (i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_D0   (o_D0),
        .o_D1   (o_D1),
        .o_s    (o_s),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, {7'd0, o_valid}, 8'd0);
        chk({tag, " ready"}, {7'd0, o_ready}, 8'd1);
        chk({tag, " count"}, {6'd0, o_count}, 8'd0);
        chk({tag, " D0"}, {4'd0, o_D0}, 8'd0);
        chk({tag, " D1"}, {4'd0, o_D1}, 8'd0);
        chk({tag, " s"}, {7'd0, o_s}, 8'd0);
    endtask

    // Monitor: a read occurs at the next posedge; compare mux output.
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got %0h expected none",
                         o_s ? o_D1 : o_D0);
            end else begin
                chk("mux_out", {4'd0, (o_s ? o_D1 : o_D0)},
                    {4'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        i_data  = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        #2;
        chk_zero("por");
        tick();
        rst = 1'b0;

        // Single word A, then read it.
        i_valid = 1'b1;
        i_data  = 4'hA;
        exp_q.push_back(4'hA);
        tick();
        i_valid = 1'b0;
        chk("single D0", {4'd0, o_D0}, 8'h0A);
        chk("single s", {7'd0, o_s}, 8'd0);
        chk("single valid", {7'd0, o_valid}, 8'd1);
        chk("single count", {6'd0, o_count}, 8'd1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("after_rd valid", {7'd0, o_valid}, 8'd0);
        chk("after_rd s", {7'd0, o_s}, 8'd1);

        // Count=1 (bank1=1, bank0 still A), reset mid-cycle.
        i_valid = 1'b1;
        i_data  = 4'h1;
        tick();
        i_valid = 1'b0;
        chk("pre_rst count", {6'd0, o_count}, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst1");
        exp_q.delete();
        tick();
        rst = 1'b0;

        // Fill and block.
        i_valid = 1'b1;
        i_data  = 4'h3;
        exp_q.push_back(4'h3);
        tick();
        i_data  = 4'h5;
        exp_q.push_back(4'h5);
        tick();
        chk("full count", {6'd0, o_count}, 8'd2);
        chk("full ready", {7'd0, o_ready}, 8'd0);
        chk("full D0", {4'd0, o_D0}, 8'h03);
        chk("full D1", {4'd0, o_D1}, 8'h05);
        i_data = 4'h7;
        tick();
        tick();
        i_valid = 1'b0;
        chk("blk D0", {4'd0, o_D0}, 8'h03);
        chk("blk D1", {4'd0, o_D1}, 8'h05);
        chk("blk count", {6'd0, o_count}, 8'd2);
        i_ready = 1'b1;
        tick();
        tick();
        i_ready = 1'b0;
        chk("drain count", {6'd0, o_count}, 8'd0);

        // Stream 0..F, consumer always ready.
        i_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            i_valid = 1'b1;
            i_data  = 4'(i);
            exp_q.push_back(4'(i));
            tick();
            chk("stream count", {6'd0, o_count}, 8'd1);
        end
        i_valid = 1'b0;
        tick();
        tick();
        i_ready = 1'b0;
        chk("stream empty", {6'd0, o_count}, 8'd0);

        // Simultaneous read/write at count=1.
        i_valid = 1'b1;
        i_data  = 4'h2;
        exp_q.push_back(4'h2);
        tick();
        i_data  = 4'h9;
        i_ready = 1'b1;
        exp_q.push_back(4'h9);
        tick();
        i_valid = 1'b0;
        i_ready = 1'b0;
        chk("rw count", {6'd0, o_count}, 8'd1);
        chk("rw s", {7'd0, o_s}, 8'd1);
        chk("rw D1", {4'd0, o_D1}, 8'h09);
        chk("rw valid", {7'd0, o_valid}, 8'd1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;

        // Stream with toggling i_ready, reset at count=2.
        i_valid = 1'b1;
        i_data  = 4'h4;
        exp_q.push_back(4'h4);
        tick();
        i_data  = 4'h5;
        i_ready = 1'b1;
        exp_q.push_back(4'h5);
        tick();
        i_data  = 4'h6;
        i_ready = 1'b0;
        exp_q.push_back(4'h6);
        tick();
        i_valid = 1'b0;
        chk("ms count", {6'd0, o_count}, 8'd2);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst2");
        exp_q.delete();
        tick();
        rst = 1'b0;
        i_valid = 1'b1;
        i_data  = 4'hC;
        exp_q.push_back(4'hC);
        tick();
        i_valid = 1'b0;
        chk("post D0", {4'd0, o_D0}, 8'h0C);
        chk("post D1", {4'd0, o_D1}, 8'h00);
        chk("post s", {7'd0, o_s}, 8'd0);
        chk("post valid", {7'd0, o_valid}, 8'd1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        tick();
        chk("sb_left", 8'(exp_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
